hwag_gap_sync: RTL

- Crank-wheel synchroniser for the hardware angle generator (HWAG).
- Times the intervals between filtered tooth edges and keeps a 3-deep period history.
- Checks each period against runtime min/max limits and detects the missing-tooth gap with a configurable ratio.
- Acquires and tracks sync via a tooth-count state machine; feeds the downstream angle/tooth-counter logic with sync_o, tooth_cnt_o and gap_o.

---
 rtl/hwag_sync_pkg.sv | 18 +
 rtl/hwag_period_capture.sv | 63 ++++++
 rtl/hwag_gap_sync.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hwag_sync_pkg.sv
// Shared types for the HWAG crank-wheel gap synchroniser.
package hwag_sync_pkg;

    typedef enum logic [2:0] {
        STOP   = 3'd0,
        FILL   = 3'd1,
        SEARCH = 3'd2,
        VERIFY = 3'd3,
        SYNC   = 3'd4
    } state_t;

    localparam int HIST_DEPTH = 3;

    function automatic int conf_width(input int confirm);
        return $clog2(confirm + 1);
    endfunction

endpackage

// File: rtl/hwag_period_capture.sv
// Tooth period timer with 3-deep capture history, history count, stall and noise flags.
module hwag_period_capture
    import hwag_sync_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             edge_i,
    input  logic [WIDTH-1:0] min_i,
    input  logic [WIDTH-1:0] max_i,
    output logic [WIDTH-1:0] cap0,
    output logic [WIDTH-1:0] cap1,
    output logic [WIDTH-1:0] cap2,
    output logic [1:0]       hist_cnt,
    output logic             evt,
    output logic             noise,
    output logic             stall
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [1:0]       HIST_FULL = 2'(HIST_DEPTH);

    logic [WIDTH-1:0] timer;
    logic [WIDTH-1:0] period_now;
    logic             noise_now;

    assign period_now = (timer == ALL_ONES) ? timer : timer + WIDTH'(1);
    // The first edge out of STOP has no meaningful period, so it is never noise.
    assign noise_now  = (hist_cnt != 2'd0) && (period_now <= min_i);
    assign stall      = ~edge_i & ~evt & (timer >= max_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer    <= '0;
            cap0     <= '0;
            cap1     <= '0;
            cap2     <= '0;
            hist_cnt <= '0;
            evt      <= 1'b0;
            noise    <= 1'b0;
        end else if (ena) begin
            evt   <= edge_i;
            noise <= edge_i & noise_now;
            if (edge_i) begin
                cap2  <= cap1;
                cap1  <= cap0;
                cap0  <= period_now;
                timer <= '0;
                if ((hist_cnt == 2'd0) || noise_now)
                    hist_cnt <= 2'd1;
                else if (hist_cnt != HIST_FULL)
                    hist_cnt <= hist_cnt + 2'd1;
            end else begin
                if (timer != ALL_ONES)
                    timer <= timer + WIDTH'(1);
                if (stall)
                    hist_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/hwag_gap_sync.sv
// Crank-wheel synchroniser: gap detection and tooth-count sync FSM over captured periods.
//   state  | meaning
//   STOP   | no edges / stalled, history empty
//   FILL   | collecting periods until the 3-deep history is full
//   SEARCH | history full, looking for the first gap
//   VERIFY | gap seen, counting teeth until CONFIRM correctly spaced gaps
//   SYNC   | locked; gap_o pulses once per revolution
module hwag_gap_sync
    import hwag_sync_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int TCNT_WIDTH = 8,
    parameter int GAP_SHIFT  = 1,
    parameter int CONFIRM    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  edge_i,
    input  logic [WIDTH-1:0]      min_i,
    input  logic [WIDTH-1:0]      max_i,
    input  logic [TCNT_WIDTH-1:0] tooth_total_i,
    output logic                  sync_o,
    output logic                  gap_o,
    output logic                  err_o,
    output logic [TCNT_WIDTH-1:0] tooth_cnt_o,
    output logic [WIDTH-1:0]      period_o,
    output logic [2:0]            state_o
);
    localparam int            CW       = conf_width(CONFIRM);
    localparam logic [CW-1:0] CONF_MAX = CW'(CONFIRM);

    logic [WIDTH-1:0]      cap0, cap1, cap2, cap1_scaled;
    logic [1:0]            hist_cnt;
    logic                  evt, noise, stall;
    logic                  gap_det, last_tooth;
    state_t                state, state_nx;
    logic [TCNT_WIDTH-1:0] tcnt, tcnt_nx;
    logic [CW-1:0]         conf, conf_nx;
    logic                  gap_nx, err_nx;

    hwag_period_capture #(.WIDTH(WIDTH)) u_capture (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .edge_i   (edge_i),
        .min_i    (min_i),
        .max_i    (max_i),
        .cap0     (cap0),
        .cap1     (cap1),
        .cap2     (cap2),
        .hist_cnt (hist_cnt),
        .evt      (evt),
        .noise    (noise),
        .stall    (stall)
    );

    // cap1 is the candidate gap; it must dwarf both of its neighbours.
    assign cap1_scaled = cap1 >> GAP_SHIFT;
    assign gap_det     = (hist_cnt == 2'(HIST_DEPTH)) && (cap0 < cap1_scaled) && (cap2 < cap1_scaled);
    assign last_tooth  = (tcnt == tooth_total_i - TCNT_WIDTH'(1));

    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        conf_nx  = conf;
        gap_nx   = 1'b0;
        err_nx   = 1'b0;
        if (evt) begin
            if (noise) begin
                err_nx   = 1'b1;
                state_nx = FILL;
            end else begin
                case (state)
                    STOP: state_nx = FILL;
                    FILL: if (hist_cnt == 2'(HIST_DEPTH)) state_nx = SEARCH;
                    SEARCH: begin
                        if (gap_det) begin
                            tcnt_nx  = '0;
                            conf_nx  = CW'(1);
                            state_nx = (CONFIRM == 1) ? SYNC : VERIFY;
                        end
                    end
                    VERIFY, SYNC: begin
                        if (gap_det && last_tooth) begin
                            tcnt_nx = '0;
                            gap_nx  = 1'b1;
                            if (conf != CONF_MAX)
                                conf_nx = conf + CW'(1);
                            if (conf_nx == CONF_MAX)
                                state_nx = SYNC;
                        end else if (gap_det) begin
                            err_nx   = 1'b1;
                            tcnt_nx  = '0;
                            conf_nx  = CW'(1);
                            state_nx = VERIFY;
                        end else if (last_tooth) begin
                            err_nx   = 1'b1;
                            state_nx = SEARCH;
                        end else begin
                            tcnt_nx = tcnt + TCNT_WIDTH'(1);
                        end
                    end
                    default: state_nx = STOP;
                endcase
            end
        end else if (stall) begin
            state_nx = STOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STOP;
            tcnt  <= '0;
            conf  <= '0;
            gap_o <= 1'b0;
            err_o <= 1'b0;
        end else if (ena) begin
            state <= state_nx;
            tcnt  <= tcnt_nx;
            conf  <= conf_nx;
            gap_o <= gap_nx;
            err_o <= err_nx;
        end
    end

    assign sync_o      = (state == SYNC);
    assign tooth_cnt_o = ((state == VERIFY) || (state == SYNC)) ? tcnt : '0;
    assign period_o    = cap0;
    assign state_o     = state;

endmodule
